// File: rtl/secure_xfer_sequencer.sv
// Command sequencer driving the memory -> security -> register datapath (FILL and COPY).
// Optional build macro SEQ_ABORT_EN adds an abort input that ends FILL/COPY early with err.
module secure_xfer_sequencer #(
  parameter int         MEM_RD_LAT = 1,
  parameter logic [9:0] PARK_REG   = 10'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [9:0]  cmd_src,
  input  logic [9:0]  cmd_dst,
  input  logic [9:0]  cmd_len,
  input  logic        cmd_encrypt,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
`ifdef SEQ_ABORT_EN
  input  logic        abort,
`endif
  output logic        mem_write,
  output logic [9:0]  mem_address,
  output logic [31:0] mem_write_data,
  output logic [9:0]  reg_address,
  output logic        encryption_on,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, FILL, COPY, DRAIN, FIN} state_t;

  state_t      state_reg;
  logic [9:0]  remain_reg;
  logic [9:0]  fill_addr_reg;
  logic [9:0]  rd_dst_reg;
  logic [2:0]  drain_reg;
  logic        aborted_reg;
  logic        pipe_v_reg [MEM_RD_LAT];
  logic [9:0]  pipe_a_reg [MEM_RD_LAT];

  logic        abort_hit;
  logic        push;
  logic        cmd_bad;
  logic [10:0] src_end;
  logic [10:0] dst_end;

`ifdef SEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign src_end = {1'b0, cmd_src} + {1'b0, cmd_len};
  assign dst_end = {1'b0, cmd_dst} + {1'b0, cmd_len};
  assign cmd_bad = (cmd_len == 10'd0) || (src_end > 11'd1024) ||
                   (!cmd_op && (dst_end > 11'd1024));

  // A read issued in the abort cycle is dropped so its register is never written.
  assign push        = (state_reg == COPY) && !abort_hit;
  assign reg_address = pipe_v_reg[MEM_RD_LAT-1] ? pipe_a_reg[MEM_RD_LAT-1] : PARK_REG;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_RD_LAT; i++) begin
        pipe_v_reg[i] <= 1'b0;
        pipe_a_reg[i] <= '0;
      end
    end else begin
      pipe_v_reg[0] <= push;
      pipe_a_reg[0] <= rd_dst_reg;
      for (int i = 1; i < MEM_RD_LAT; i++) begin
        pipe_v_reg[i] <= pipe_v_reg[i-1];
        pipe_a_reg[i] <= pipe_a_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cmd_ready      <= 1'b1;
      wr_ready       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      encryption_on  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      remain_reg     <= '0;
      fill_addr_reg  <= '0;
      rd_dst_reg     <= '0;
      drain_reg      <= '0;
      aborted_reg    <= 1'b0;
    end else begin
      mem_write <= 1'b0;
      case (state_reg)
        IDLE: ;
        FILL: begin
          if (abort_hit) begin
            state_reg <= FIN;
            wr_ready  <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            done      <= 1'b1;
            err       <= 1'b1;
          end else if (wr_valid) begin
            mem_write      <= 1'b1;
            mem_address    <= fill_addr_reg;
            mem_write_data <= wr_data;
            fill_addr_reg  <= fill_addr_reg + 10'd1;
            remain_reg     <= remain_reg - 10'd1;
            if (remain_reg == 10'd1) begin
              state_reg <= FIN;
              wr_ready  <= 1'b0;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
              done      <= 1'b1;
              err       <= 1'b0;
            end
          end
        end
        COPY: begin
          if (abort_hit || remain_reg == 10'd0) begin
            state_reg   <= DRAIN;
            drain_reg   <= 3'(MEM_RD_LAT - 1);
            aborted_reg <= abort_hit;
          end else begin
            mem_address <= mem_address + 10'd1;
            rd_dst_reg  <= rd_dst_reg + 10'd1;
            remain_reg  <= remain_reg - 10'd1;
          end
        end
        DRAIN: begin
          if (drain_reg == 3'd0) begin
            state_reg <= FIN;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            done      <= 1'b1;
            err       <= aborted_reg;
          end else begin
            drain_reg <= drain_reg - 3'd1;
          end
        end
        FIN: begin
          state_reg <= IDLE;
          done      <= 1'b0;
          err       <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase

      // cmd_ready is high in IDLE and FIN, so a new command may land on the done cycle.
      if (cmd_valid && cmd_ready) begin
        if (cmd_bad) begin
          state_reg <= FIN;
          done      <= 1'b1;
          err       <= 1'b1;
        end else begin
          busy          <= 1'b1;
          cmd_ready     <= 1'b0;
          encryption_on <= cmd_encrypt;
          if (cmd_op) begin
            state_reg     <= FILL;
            wr_ready      <= 1'b1;
            fill_addr_reg <= cmd_src;
            remain_reg    <= cmd_len;
          end else begin
            state_reg   <= COPY;
            mem_address <= cmd_src;
            rd_dst_reg  <= cmd_dst;
            remain_reg  <= cmd_len - 10'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_secure_xfer_sequencer.sv
// Randomized bench for secure_xfer_sequencer: three instances (read latency 1, 2, 3) share
// stimulus and are checked every cycle against a command-level timing model.
module tb_secure_xfer_sequencer;

  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_op = 1'b0;
  logic [9:0]  cmd_src = '0;
  logic [9:0]  cmd_dst = '0;
  logic [9:0]  cmd_len = '0;
  logic        cmd_encrypt = 1'b0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        abort = 1'b0;

  logic        cmd_ready_w [ND];
  logic        wr_ready_w  [ND];
  logic        mem_write_w [ND];
  logic [9:0]  mem_addr_w  [ND];
  logic [31:0] mem_wdata_w [ND];
  logic [9:0]  reg_addr_w  [ND];
  logic        enc_w       [ND];
  logic        busy_w      [ND];
  logic        done_w      [ND];
  logic        err_w       [ND];

  logic        cur_enc [ND];
  int          n_vec  = 0;
  int          n_miss = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    secure_xfer_sequencer #(
      .MEM_RD_LAT(gi + 1),
      .PARK_REG  (gi == 0 ? 10'h000 : (gi == 1 ? 10'h03A : 10'h3FF))
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready_w[gi]),
      .cmd_op        (cmd_op),
      .cmd_src       (cmd_src),
      .cmd_dst       (cmd_dst),
      .cmd_len       (cmd_len),
      .cmd_encrypt   (cmd_encrypt),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready_w[gi]),
      .wr_data       (wr_data),
`ifdef SEQ_ABORT_EN
      .abort         (abort),
`endif
      .mem_write     (mem_write_w[gi]),
      .mem_address   (mem_addr_w[gi]),
      .mem_write_data(mem_wdata_w[gi]),
      .reg_address   (reg_addr_w[gi]),
      .encryption_on (enc_w[gi]),
      .busy          (busy_w[gi]),
      .done          (done_w[gi]),
      .err           (err_w[gi])
    );
  end

  function automatic logic [9:0] park_of(input int d);
    return (d == 0) ? 10'h000 : ((d == 1) ? 10'h03A : 10'h3FF);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string why);
    for (int d = 0; d < ND; d++) begin
      check_val($sformatf("%s cmd_ready d%0d", why, d), cmd_ready_w[d], 1);
      check_val($sformatf("%s wr_ready d%0d", why, d), wr_ready_w[d], 0);
      check_val($sformatf("%s mem_write d%0d", why, d), mem_write_w[d], 0);
      check_val($sformatf("%s mem_address d%0d", why, d), mem_addr_w[d], 0);
      check_val($sformatf("%s mem_write_data d%0d", why, d), mem_wdata_w[d], 0);
      check_val($sformatf("%s reg_address d%0d", why, d), reg_addr_w[d], park_of(d));
      check_val($sformatf("%s encryption_on d%0d", why, d), enc_w[d], 0);
      check_val($sformatf("%s busy d%0d", why, d), busy_w[d], 0);
      check_val($sformatf("%s done d%0d", why, d), done_w[d], 0);
      check_val($sformatf("%s err d%0d", why, d), err_w[d], 0);
      cur_enc[d] = 1'b0;
    end
  endtask

  // Called right after a falling edge; the command is offered for the next rising edge.
  task automatic run_cmd(input logic op, input logic [9:0] src, input logic [9:0] dst,
                         input logic [9:0] len, input logic enc, input bit gap_mode,
                         input int abort_at, input int rst_at);
    bit          bad, aborted, act, is_done;
    int          last_issue, n_eff, t, tmax, k;
    int          done_t [ND];
    int          hs     [ND];
    bit          pv     [ND];
    logic [9:0]  pa     [ND];
    logic [31:0] pd     [ND];
    logic [9:0]  exp_reg;
    string       sfx;

    bad     = (len == 0) || (int'(src) + int'(len) > 1024) ||
              (!op && (int'(dst) + int'(len) > 1024));
    aborted = !bad && !op && (abort_at >= 0) && (abort_at < int'(len));
    last_issue = aborted ? abort_at + 1 : int'(len);
    n_eff      = aborted ? abort_at : int'(len);
    for (int d = 0; d < ND; d++) begin
      hs[d] = 0;
      pv[d] = 1'b0;
      pa[d] = '0;
      pd[d] = '0;
      done_t[d] = bad ? 1 : (op ? (1 << 30) : last_issue + (d + 1) + 1);
    end
    $display("cmd %s src=%h dst=%h len=%0d enc=%0d abort_at=%0d rst_at=%0d expect_%s",
             op ? "FILL" : "COPY", src, dst, len, enc, abort_at, rst_at,
             bad ? "reject" : (aborted ? "abort" : "ok"));

    cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_encrypt = enc;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (!bad) for (int d = 0; d < ND; d++) cur_enc[d] = enc;

    t = 1;
    forever begin
      for (int d = 0; d < ND; d++) begin
        sfx = $sformatf("d%0d t%0d", d, t);
        act     = t < done_t[d];
        is_done = t == done_t[d];
        k = t - 1 - (d + 1);
        exp_reg = (!bad && !op && k >= 0 && k < n_eff) ? dst + 10'(k) : park_of(d);
        check_val({"busy ", sfx}, busy_w[d], act);
        check_val({"cmd_ready ", sfx}, cmd_ready_w[d], !act);
        check_val({"wr_ready ", sfx}, wr_ready_w[d], act && op && !bad);
        check_val({"done ", sfx}, done_w[d], is_done);
        check_val({"err ", sfx}, err_w[d], is_done && (bad || aborted));
        check_val({"reg_address ", sfx}, reg_addr_w[d], exp_reg);
        check_val({"encryption_on ", sfx}, enc_w[d], cur_enc[d]);
        check_val({"mem_write ", sfx}, mem_write_w[d], pv[d]);
        if (pv[d]) begin
          check_val({"mem_address_wr ", sfx}, mem_addr_w[d], pa[d]);
          check_val({"mem_write_data ", sfx}, mem_wdata_w[d], pd[d]);
        end
        if (!bad && !op && t <= last_issue)
          check_val({"mem_address_rd ", sfx}, mem_addr_w[d], src + 10'(t - 1));
        pv[d] = 1'b0;
      end

      if (rst_at == t) begin
        rst_n = 1'b0;
        wr_valid = 1'b0;
        #1;
        check_reset("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end

      if (op && !bad) begin
        wr_valid = gap_mode ? (t != 3) : ($urandom_range(0, 3) != 0);
        wr_data  = gap_mode ? 32'hA0 + 32'(hs[0]) : $urandom;
      end else begin
        wr_valid = 1'b0;
      end
      abort = aborted && (t == last_issue);

      for (int d = 0; d < ND; d++) begin
        if (op && !bad && t < done_t[d] && wr_valid) begin
          pv[d] = 1'b1;
          pa[d] = src + 10'(hs[d]);
          pd[d] = wr_data;
          hs[d]++;
          if (hs[d] == int'(len)) done_t[d] = t + 1;
        end
      end

      tmax = 0;
      for (int d = 0; d < ND; d++) if (done_t[d] > tmax) tmax = done_t[d];
      if (t >= tmax) break;
      if (t > 4000) begin
        check_val("timeout waiting for done", 32'(t), 32'(tmax));
        break;
      end
      @(negedge clk);
      t++;
    end
    wr_valid = 1'b0;
    abort    = 1'b0;
  endtask

  initial begin
    logic        r_op, r_enc;
    logic [9:0]  r_src, r_dst, r_len;
    int          r_abort;

    for (int d = 0; d < ND; d++) cur_enc[d] = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd(1'b1, 10'h010, 10'h000, 10'd4, 1'b0, 1'b1, -1, -1);
    run_cmd(1'b0, 10'h010, 10'h005, 10'd4, 1'b1, 1'b0, -1, -1);
    run_cmd(1'b0, 10'h100, 10'h020, 10'd3, 1'b0, 1'b0, -1, -1);
    run_cmd(1'b0, 10'h3FE, 10'h000, 10'd2, 1'b1, 1'b0, -1, -1);
    run_cmd(1'b1, 10'h3FE, 10'h000, 10'd2, 1'b0, 1'b0, -1, -1);
    run_cmd(1'b0, 10'h3FF, 10'h000, 10'd2, 1'b0, 1'b0, -1, -1);
    run_cmd(1'b1, 10'h3FF, 10'h000, 10'd2, 1'b1, 1'b0, -1, -1);
    run_cmd(1'b1, 10'h020, 10'h000, 10'd0, 1'b1, 1'b0, -1, -1);
    run_cmd(1'b0, 10'h000, 10'h3FF, 10'd2, 1'b1, 1'b0, -1, -1);
    run_cmd(1'b0, 10'h040, 10'h010, 10'd6, 1'b1, 1'b0, -1, 3);
    run_cmd(1'b1, 10'h200, 10'h000, 10'd5, 1'b1, 1'b0, -1, -1);
    run_cmd(1'b0, 10'h080, 10'h030, 10'd5, 1'b0, 1'b0, -1, -1);
`ifdef SEQ_ABORT_EN
    run_cmd(1'b0, 10'h060, 10'h100, 10'd8, 1'b1, 1'b0, 2, -1);
`endif

    for (int n = 0; n < 30; n++) begin
      r_op  = 1'($urandom_range(0, 1));
      r_enc = 1'($urandom_range(0, 1));
      r_len = 10'($urandom_range(0, 12));
      r_src = 10'($urandom_range(0, 1023));
      r_dst = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) == 0) r_src = 10'(1024 - int'(r_len) + int'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) r_dst = 10'(1024 - int'(r_len) + int'($urandom_range(0, 1)));
      r_abort = -1;
`ifdef SEQ_ABORT_EN
      if ($urandom_range(0, 2) == 0) r_abort = int'($urandom_range(0, 9));
`endif
      run_cmd(r_op, r_src, r_dst, r_len, r_enc, 1'b0, r_abort, -1);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
